// File: rtl/butterfly_unit_cplx_pipe_if.sv
// Bundles the operand, twiddle, control and result signals of the complex butterfly.
// The master side drives samples and controls, the slave (datapath) returns results.
interface butterfly_unit_cplx_pipe_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int CNT_W  = 16
);
    logic                     en;
    logic                     valid_in;
    logic                     scale;
    logic                     clr_stat;
    logic signed [DATA_W-1:0] a_real;
    logic signed [DATA_W-1:0] a_imag;
    logic signed [DATA_W-1:0] b_real;
    logic signed [DATA_W-1:0] b_imag;
    logic signed [COEF_W-1:0] W_real;
    logic signed [COEF_W-1:0] W_imag;
    logic                     valid_out;
    logic signed [DATA_W-1:0] y0_real;
    logic signed [DATA_W-1:0] y0_imag;
    logic signed [DATA_W-1:0] y1_real;
    logic signed [DATA_W-1:0] y1_imag;
    logic                     sat_out;
    logic [CNT_W-1:0]         sat_count;

    modport master (
        output en, valid_in, scale, clr_stat,
        output a_real, a_imag, b_real, b_imag, W_real, W_imag,
        input  valid_out, y0_real, y0_imag, y1_real, y1_imag, sat_out, sat_count
    );

    modport slave (
        input  en, valid_in, scale, clr_stat,
        input  a_real, a_imag, b_real, b_imag, W_real, W_imag,
        output valid_out, y0_real, y0_imag, y1_real, y1_imag, sat_out, sat_count
    );
endinterface

// File: rtl/butterfly_unit_cplx_pipe.sv
// Radix-2 DIT complex butterfly y0 = a + b*W, y1 = a - b*W over three stall-able stages,
// with half-up rounding of b*W, optional 1/2 scaling, output saturation and a sticky clip counter.
module butterfly_unit_cplx_pipe #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    butterfly_unit_cplx_pipe_if.slave bus
);
    localparam int P_W   = DATA_W + COEF_W + 1;
    // One guard bit above the product width keeps a +/- bw exact for any COEF_FRAC.
    localparam int SUM_W = P_W + 1;

    localparam logic signed [P_W-1:0]   RND      = {{(P_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [SUM_W-1:0] ONE      = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic signed [SUM_W-1:0] scale_fn(
        input logic signed [SUM_W-1:0] v,
        input logic                    sc
    );
        logic signed [SUM_W-1:0] t;
        t = v + ONE;
        if (sc) begin
            return t >>> 1'b1;
        end else begin
            return v;
        end
    endfunction

    // Returns {clip_flag, clipped_value}.
    function automatic logic [DATA_W:0] sat_fn(input logic signed [SUM_W-1:0] v);
        logic [DATA_W:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            res = {1'b0, v[DATA_W-1:0]};
        end
        return res;
    endfunction

    logic                     r1_valid, r1_scale;
    logic signed [DATA_W-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im;
    logic signed [COEF_W-1:0] r1_w_re, r1_w_im;

    logic                     r2_valid, r2_scale;
    logic signed [DATA_W-1:0] r2_a_re, r2_a_im;
    logic signed [P_W-1:0]    r2_p_re, r2_p_im;

    logic                     r_valid_out, r_sat_out;
    logic signed [DATA_W-1:0] r_y0_re, r_y0_im, r_y1_re, r_y1_im;
    logic [CNT_W-1:0]         r_sat_count;

    logic signed [P_W-1:0]    w_p_re, w_p_im;
    logic signed [P_W-1:0]    w_bw_re, w_bw_im;
    logic [DATA_W:0]          w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic                     w_clip;

    // Stage 1: capture operands, twiddle and sample attributes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r1_valid <= 1'b0;
            r1_scale <= 1'b0;
            r1_a_re  <= '0;
            r1_a_im  <= '0;
            r1_b_re  <= '0;
            r1_b_im  <= '0;
            r1_w_re  <= '0;
            r1_w_im  <= '0;
        end else if (bus.en) begin
            r1_valid <= bus.valid_in;
            r1_scale <= bus.scale;
            r1_a_re  <= bus.a_real;
            r1_a_im  <= bus.a_imag;
            r1_b_re  <= bus.b_real;
            r1_b_im  <= bus.b_imag;
            r1_w_re  <= bus.W_real;
            r1_w_im  <= bus.W_imag;
        end
    end

    // Full-precision complex product b*W; operands are widened first so nothing is lost.
    always_comb begin
        w_p_re = P_W'(r1_b_re) * P_W'(r1_w_re) - P_W'(r1_b_im) * P_W'(r1_w_im);
        w_p_im = P_W'(r1_b_re) * P_W'(r1_w_im) + P_W'(r1_b_im) * P_W'(r1_w_re);
    end

    // Stage 2: hold the exact product alongside the delayed a operand.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r2_valid <= 1'b0;
            r2_scale <= 1'b0;
            r2_a_re  <= '0;
            r2_a_im  <= '0;
            r2_p_re  <= '0;
            r2_p_im  <= '0;
        end else if (bus.en) begin
            r2_valid <= r1_valid;
            r2_scale <= r1_scale;
            r2_a_re  <= r1_a_re;
            r2_a_im  <= r1_a_im;
            r2_p_re  <= w_p_re;
            r2_p_im  <= w_p_im;
        end
    end

    // Round b*W half-up, form a +/- bw, optionally halve, then clip to the output range.
    always_comb begin
        w_bw_re = (r2_p_re + RND) >>> COEF_FRAC;
        w_bw_im = (r2_p_im + RND) >>> COEF_FRAC;
        w_y0_re = sat_fn(scale_fn(SUM_W'(r2_a_re) + SUM_W'(w_bw_re), r2_scale));
        w_y0_im = sat_fn(scale_fn(SUM_W'(r2_a_im) + SUM_W'(w_bw_im), r2_scale));
        w_y1_re = sat_fn(scale_fn(SUM_W'(r2_a_re) - SUM_W'(w_bw_re), r2_scale));
        w_y1_im = sat_fn(scale_fn(SUM_W'(r2_a_im) - SUM_W'(w_bw_im), r2_scale));
        w_clip  = w_y0_re[DATA_W] | w_y0_im[DATA_W] | w_y1_re[DATA_W] | w_y1_im[DATA_W];
    end

    // Stage 3: registered results; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid_out <= 1'b0;
            r_sat_out   <= 1'b0;
            r_y0_re     <= '0;
            r_y0_im     <= '0;
            r_y1_re     <= '0;
            r_y1_im     <= '0;
        end else if (bus.en) begin
            r_valid_out <= r2_valid;
            r_sat_out   <= w_clip;
            r_y0_re     <= w_y0_re[DATA_W-1:0];
            r_y0_im     <= w_y0_im[DATA_W-1:0];
            r_y1_re     <= w_y1_re[DATA_W-1:0];
            r_y1_im     <= w_y1_im[DATA_W-1:0];
        end
    end

    // Sticky clip counter: clear has priority and ignores the stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (bus.clr_stat) begin
            r_sat_count <= '0;
        end else if (bus.en && r2_valid && w_clip && (r_sat_count != CNT_MAX)) begin
            r_sat_count <= r_sat_count + CNT_ONE;
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.sat_out   = r_sat_out;
    assign bus.y0_real   = r_y0_re;
    assign bus.y0_imag   = r_y0_im;
    assign bus.y1_real   = r_y1_re;
    assign bus.y1_imag   = r_y1_im;
    assign bus.sat_count = r_sat_count;
endmodule
